// File: rtl/bpu_pkg.sv
// Branch predictor shared definitions.
// Holds the index/tag width helpers, the direction-counter constants and
// the BTB entry layout for the default configuration (32-bit PC, 16
// entries, 2-bit counters).
package bpu_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_ENTRIES  = 16;
    localparam int DEF_CTR_BITS = 2;

    // PC[1:0] never reach the table, so the index starts at bit 2.
    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_width(input int xlen, input int entries);
        return xlen - $clog2(entries) - 2;
    endfunction

    // Freshly allocated branches start weakly taken.
    function automatic int weak_t_of(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    function automatic int ctr_max_of(input int ctr_bits);
        return (1 << ctr_bits) - 1;
    endfunction

    localparam int WEAK_T    = weak_t_of(DEF_CTR_BITS);
    localparam int CTR_MAX   = ctr_max_of(DEF_CTR_BITS);
    localparam int DEF_TAG_W = tag_width(DEF_XLEN, DEF_ENTRIES);

    typedef struct packed {
        logic                    valid;
        logic [DEF_TAG_W-1:0]    tag;
        logic [DEF_XLEN-1:0]     target;
        logic [DEF_CTR_BITS-1:0] ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (clears to 0)
//   clr_i          synchronous clear (highest priority)
//   max_i          force to all-ones
//   ld_i/ld_val_i  load an arbitrary value
//   inc_i, dec_i   saturating step; both together hold the value
//   cnt_o          current count
module sat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             max_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (max_i) begin
            cnt_d = MAX_VAL;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (inc_i && !dec_i) begin
            if (cnt_q != MAX_VAL) cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters and saturating branch/mispredict performance counters.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   PCF -> PredTakenF/PredTargetF    fetch-stage lookup (combinational)
//   UpdValidE, UpdJumpE, PCE, TakenE, PCTargetE,
//   PredTakenE, PredTargetE  resolved branch from EX, trains the table
//   MispredictE, RedirectPCE redirect request and corrective PC
//   FlushTbl                 invalidate all entries
//   BranchCount, MissCount   saturating performance counters
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    output logic [XLEN-1:0]  PredTargetF,
    input  logic             UpdValidE,
    input  logic             UpdJumpE,
    input  logic [XLEN-1:0]  PCE,
    input  logic             TakenE,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic             PredTakenE,
    input  logic [XLEN-1:0]  PredTargetE,
    output logic             MispredictE,
    output logic [XLEN-1:0]  RedirectPCE,
    input  logic             FlushTbl,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MissCount
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam int TAG_W = tag_width(XLEN, ENTRIES);
    localparam logic [CTR_BITS-1:0] WEAK_VAL = CTR_BITS'(weak_t_of(CTR_BITS));

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [XLEN-1:0]     target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    // Fetch-side lookup
    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;

    assign idx_f       = PCF[IDX_W+1:2];
    assign tag_f       = PCF[XLEN-1:IDX_W+2];
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredTakenF  = hit_f && ctr_q[idx_f][CTR_BITS-1];
    assign PredTargetF = hit_f ? target_q[idx_f] : PCF + XLEN'(4);

    // EX-side resolution
    logic             mispredict_raw;
    assign mispredict_raw = UpdValidE &&
                            ((PredTakenE != TakenE) || (TakenE && (PredTargetE != PCTargetE)));
    assign MispredictE = rst && mispredict_raw;
    assign RedirectPCE = !rst ? '0 : (TakenE ? PCTargetE : PCE + XLEN'(4));

    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_e;
    logic             upd_en;
    logic             taken_eff;
    logic             alloc_e;
    logic             tgt_wr_e;

    assign idx_e     = PCE[IDX_W+1:2];
    assign tag_e     = PCE[XLEN-1:IDX_W+2];
    assign hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    // A flush in the same cycle suppresses every table write.
    assign upd_en    = UpdValidE && !FlushTbl;
    assign taken_eff = TakenE || UpdJumpE;
    assign alloc_e   = upd_en && !hit_e && taken_eff;
    assign tgt_wr_e  = upd_en && hit_e && taken_eff;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (FlushTbl) begin
            valid_d = '0;
        end else if (alloc_e) begin
            valid_d[idx_e]  = 1'b1;
            tag_d[idx_e]    = tag_e;
            target_d[idx_e] = PCTargetE;
        end else if (tgt_wr_e) begin
            target_d[idx_e] = PCTargetE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

    // Direction counters: a jump always pins its entry to strongly taken,
    // a non-jump allocation starts weakly taken, hits step up/down.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_dir
        logic sel;
        assign sel = upd_en && (idx_e == IDX_W'(g));

        sat_counter #(.WIDTH(CTR_BITS)) u_ctr (
            .clk_i   (clk),
            .rst_ni  (rst),
            .clr_i   (1'b0),
            .max_i   (sel && UpdJumpE),
            .ld_i    (sel && !UpdJumpE && !hit_e && TakenE),
            .ld_val_i(WEAK_VAL),
            .inc_i   (sel && !UpdJumpE && hit_e && TakenE),
            .dec_i   (sel && !UpdJumpE && hit_e && !TakenE),
            .cnt_o   (ctr_q[g])
        );
    end

    // Performance counters are deliberately untouched by FlushTbl.
    sat_counter #(.WIDTH(CNT_W)) u_branch_cnt (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (1'b0),
        .max_i   (1'b0),
        .ld_i    (1'b0),
        .ld_val_i('0),
        .inc_i   (UpdValidE),
        .dec_i   (1'b0),
        .cnt_o   (BranchCount)
    );

    sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (1'b0),
        .max_i   (1'b0),
        .ld_i    (1'b0),
        .ld_val_i('0),
        .inc_i   (MispredictE),
        .dec_i   (1'b0),
        .cnt_o   (MissCount)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios followed by random
// traffic, all compared against an integer-level behavioural model.
module tb_branch_predictor;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
    localparam int CTR_TOP = 3;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdValidE;
    logic        UpdJumpE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] PCTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
    logic        FlushTbl;
    logic [CNT_W-1:0] BranchCount;
    logic [CNT_W-1:0] MissCount;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_BITS(2), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .PCF        (PCF),
        .PredTakenF (PredTakenF),
        .PredTargetF(PredTargetF),
        .UpdValidE  (UpdValidE),
        .UpdJumpE   (UpdJumpE),
        .PCE        (PCE),
        .TakenE     (TakenE),
        .PCTargetE  (PCTargetE),
        .PredTakenE (PredTakenE),
        .PredTargetE(PredTargetE),
        .MispredictE(MispredictE),
        .RedirectPCE(RedirectPCE),
        .FlushTbl   (FlushTbl),
        .BranchCount(BranchCount),
        .MissCount  (MissCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one record per table slot, plain integers.
    logic        m_valid  [16];
    logic [31:0] m_tag    [16];
    logic [31:0] m_target [16];
    int          m_ctr    [16];
    int          m_bc;
    int          m_mc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 32'h0;
            m_target[i] = 32'h0;
            m_ctr[i]    = 0;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int  slot;
        logic hit;
        slot = int'((pc / 4) % 16);
        hit  = m_valid[slot] && (m_tag[slot] == pc / 64);
        tk   = hit && (m_ctr[slot] >= 2);
        tg   = hit ? m_target[slot] : pc + 32'd4;
    endtask

    task automatic m_update(input logic mp);
        int   slot;
        logic hit;
        logic tk;
        if (FlushTbl) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else if (UpdValidE) begin
            slot = int'((PCE / 4) % 16);
            hit  = m_valid[slot] && (m_tag[slot] == PCE / 64);
            tk   = TakenE || UpdJumpE;
            if (hit) begin
                if (UpdJumpE)            m_ctr[slot] = CTR_TOP;
                else if (tk)             m_ctr[slot] = (m_ctr[slot] == CTR_TOP) ? CTR_TOP : m_ctr[slot] + 1;
                else                     m_ctr[slot] = (m_ctr[slot] == 0) ? 0 : m_ctr[slot] - 1;
                if (tk) m_target[slot] = PCTargetE;
            end else if (tk) begin
                m_valid[slot]  = 1'b1;
                m_tag[slot]    = PCE / 64;
                m_target[slot] = PCTargetE;
                m_ctr[slot]    = UpdJumpE ? CTR_TOP : 2;
            end
        end
        if (UpdValidE && m_bc < CNT_MAX) m_bc++;
        if (mp && m_mc < CNT_MAX) m_mc++;
    endtask

    // Check all outputs against the model, then clock and train the model.
    task automatic cycle();
        logic        tk;
        logic [31:0] tg;
        logic        mp;
        logic [31:0] rp;
        #1;
        m_lookup(PCF, tk, tg);
        mp = UpdValidE && ((PredTakenE != TakenE) || (TakenE && (PredTargetE != PCTargetE)));
        rp = TakenE ? PCTargetE : PCE + 32'd4;
        chk("pred_taken",  32'(PredTakenF),  32'(tk));
        chk("pred_target", PredTargetF,      tg);
        chk("mispredict",  32'(MispredictE), 32'(mp));
        chk("redirect",    RedirectPCE,      rp);
        chk("branch_cnt",  32'(BranchCount), 32'(m_bc));
        chk("miss_cnt",    32'(MissCount),   32'(m_mc));
        @(posedge clk);
        m_update(mp);
        #1;
    endtask

    task automatic idle();
        UpdValidE   = 1'b0;
        UpdJumpE    = 1'b0;
        PCE         = 32'h0;
        TakenE      = 1'b0;
        PCTargetE   = 32'h0;
        PredTakenE  = 1'b0;
        PredTargetE = 32'h0;
        FlushTbl    = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptg, input logic jmp);
        UpdValidE   = 1'b1;
        UpdJumpE    = jmp;
        PCE         = pc;
        TakenE      = tk;
        PCTargetE   = tgt;
        PredTakenE  = ptk;
        PredTargetE = ptg;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) pc = pc | 32'hFFFF_FF00;
        return pc;
    endfunction

    initial begin
        logic        pt;
        logic [31:0] pg;
        logic [31:0] rpc;

        // Reset with an update presented: EX outputs must stay masked.
        rst = 1'b0;
        idle();
        PCF = 32'h40;
        upd(32'h40, 1'b1, 32'h1234, 1'b0, 32'h0, 1'b0);
        m_reset();
        #1;
        chk("rst_mispredict", 32'(MispredictE), 32'h0);
        chk("rst_redirect",   RedirectPCE,      32'h0);
        repeat (2) @(posedge clk);
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset state lookup
        PCF = 32'h40;
        #1;
        chk("reset_taken",  32'(PredTakenF),  32'h0);
        chk("reset_target", PredTargetF,      32'h44);
        chk("reset_bcnt",   32'(BranchCount), 32'h0);
        chk("reset_mcnt",   32'(MissCount),   32'h0);
        cycle();

        // Allocate; same-cycle lookup still sees the old (empty) entry.
        upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h44, 1'b0);
        #1;
        chk("alloc_mispredict", 32'(MispredictE), 32'h1);
        chk("alloc_redirect",   RedirectPCE,      32'h20);
        chk("alloc_samecycle",  32'(PredTakenF),  32'h0);
        cycle();
        idle();
        #1;
        chk("alloc_taken",  32'(PredTakenF),  32'h1);
        chk("alloc_target", PredTargetF,      32'h20);
        chk("alloc_bcnt",   32'(BranchCount), 32'h1);
        chk("alloc_mcnt",   32'(MissCount),   32'h1);
        cycle();

        // Hysteresis: 2 -> 1 -> 0
        upd(32'h40, 1'b0, 32'h20, 1'b1, 32'h20, 1'b0);
        #1;
        chk("hyst_mispredict", 32'(MispredictE), 32'h1);
        chk("hyst_redirect",   RedirectPCE,      32'h44);
        cycle();
        idle();
        #1;
        chk("hyst_weak_nt", 32'(PredTakenF), 32'h0);
        chk("hyst_hit_tgt", PredTargetF,     32'h20);
        cycle();
        upd(32'h40, 1'b0, 32'h20, 1'b1, 32'h20, 1'b0);
        cycle();
        idle();
        #1;
        chk("hyst_mcnt", 32'(MissCount), 32'h3);
        cycle();

        // Aliasing on index 0
        PCF = 32'h80;
        #1;
        chk("alias_miss", 32'(PredTakenF), 32'h0);
        upd(32'h80, 1'b1, 32'h100, 1'b0, 32'h84, 1'b0);
        cycle();
        idle();
        #1;
        chk("alias_taken",  32'(PredTakenF), 32'h1);
        chk("alias_target", PredTargetF,     32'h100);
        cycle();
        PCF = 32'h40;
        #1;
        chk("alias_evicted", PredTargetF, 32'h44);
        cycle();

        // Jump, then flush colliding with an update
        upd(32'h10, 1'b1, 32'h200, 1'b0, 32'h14, 1'b1);
        cycle();
        idle();
        PCF = 32'h10;
        #1;
        chk("jump_taken",  32'(PredTakenF), 32'h1);
        chk("jump_target", PredTargetF,     32'h200);
        upd(32'h14, 1'b1, 32'h300, 1'b0, 32'h18, 1'b0);
        FlushTbl = 1'b1;
        cycle();
        idle();
        #1;
        chk("flush_0x10", 32'(PredTakenF), 32'h0);
        cycle();
        PCF = 32'h14;
        #1;
        chk("flush_0x14", PredTargetF, 32'h18);
        cycle();

        // PC+4 wraps at the top of the address space
        PCF = 32'hFFFF_FFFC;
        PCE = 32'hFFFF_FFFC;
        #1;
        chk("wrap_fetch",    PredTargetF, 32'h0);
        chk("wrap_redirect", RedirectPCE, 32'h0);
        cycle();
        idle();

        // Counter saturation
        for (int k = 0; k < 20; k++) begin
            upd(32'h300, 1'b1, 32'h500, 1'b0, 32'h304, 1'b0);
            cycle();
        end
        idle();
        #1;
        chk("sat_bcnt", 32'(BranchCount), 32'(CNT_MAX));
        chk("sat_mcnt", 32'(MissCount),   32'(CNT_MAX));
        cycle();

        // Reset asserted mid-update discards the update
        upd(32'h24, 1'b1, 32'h900, 1'b0, 32'h28, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        m_reset();
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        PCF = 32'h24;
        #1;
        chk("rstmid_miss", PredTargetF,      32'h28);
        chk("rstmid_bcnt", 32'(BranchCount), 32'h0);
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            PCF = rand_pc();
            if ($urandom_range(0, 1) == 1) begin
                rpc = rand_pc();
                m_lookup(rpc, pt, pg);
                UpdJumpE = ($urandom_range(0, 5) == 0);
                UpdValidE = 1'b1;
                PCE = rpc;
                TakenE = UpdJumpE ? 1'b1 : 1'($urandom_range(0, 1));
                PCTargetE = ($urandom_range(0, 3) == 0) ? $urandom()
                                                        : 32'h1000 + (rpc & 32'hFC);
                PredTakenE  = ($urandom_range(0, 4) == 0) ? ~pt : pt;
                PredTargetE = pg;
            end
            FlushTbl = ($urandom_range(0, 31) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised direct-mapped branch target buffer (BTB) with saturating direction counters for the 5-stage pipeline. It removes the fixed predict-not-taken behaviour of the current core. In IF it predicts a taken branch or jump and its target from PCF. In EX it takes the resolved outcome, flags mispredictions, supplies the corrective PC and trains the table. Saturating performance counters record branch and mispredict totals.

## Interface
- XLEN, 32, address/data width
- ENTRIES, 16, table depth; power of two, ≥2; IDX_W = log2(ENTRIES)
- CTR_BITS, 2, direction counter width, ≥1
- CNT_W, 16, performance counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- PCF  in  XLEN  fetch-stage PC
- PredTakenF  out  1  prediction for PCF: taken
- PredTargetF  out  XLEN  predicted target for PCF
- UpdValidE  in  1  a non-flushed branch/jump resolved in EX this cycle
- UpdJumpE  in  1  resolved instruction is an unconditional jump
- PCE  in  XLEN  PC of the resolved instruction
- TakenE  in  1  actual outcome (PCSrcE)
- PCTargetE  in  XLEN  actual taken target
- PredTakenE  in  1  prediction that travelled with the instruction
- PredTargetE  in  XLEN  predicted target that travelled with the instruction
- MispredictE  out  1  redirect required
- RedirectPCE  out  XLEN  corrective PC
- FlushTbl  in  1  invalidate every entry
- BranchCount  out  CNT_W  resolved branches/jumps, saturating
- MissCount  out  CNT_W  mispredictions, saturating

## Operation
- Address split: index = PC[IDX_W+1:2]; tag = PC[XLEN-1:IDX_W+2]; PC[1:0] ignored.
- Entry fields: valid, tag, target, ctr[CTR_BITS-1:0].
- Lookup (combinational from registered state):
  - hit = valid & tag match.
  - PredTakenF = hit & ctr MSB.
  - PredTargetF = hit ? target : PCF+4.
- Mispredict:
  - MispredictE = UpdValidE & ((PredTakenE≠TakenE) | (TakenE & PredTargetE≠PCTargetE)).
  - RedirectPCE = TakenE ? PCTargetE : PCE+4, driven every cycle.
- Update on UpdValidE, indexed by PCE:
  - Hit, taken: ctr saturating +1; target ← PCTargetE.
  - Hit, not taken: ctr saturating −1.
  - Miss, taken: allocate/overwrite. valid=1, tag, target ← PCTargetE, ctr = WEAK_T (1<<(CTR_BITS-1)).
  - Miss, not taken: no write.
  - UpdJumpE=1: ctr forced to all-ones; TakenE treated as 1.
- Perf counters:
  - BranchCount +1 per UpdValidE.
  - MissCount +1 per MispredictE.
  - Both hold at 2^CNT_W−1.
- FlushTbl clears all valid bits next edge. FlushTbl and an update in the same cycle: flush wins, no allocation. Perf counters are not cleared by FlushTbl.
- Arithmetic: +4 is modulo 2^XLEN (wraps from 0xFFFFFFFC to 0).

## Timing
- Lookup latency 0: prediction valid in the same cycle as PCF.
- Update latency 1: a lookup at the updated index sees the new entry from the next cycle. A same-cycle lookup of that index returns the pre-update contents.
- MispredictE and RedirectPCE are combinational from EX inputs and masked to 0 while rst is low.
- Reset (async assert, sync-safe deassert): all valid=0, ctr=0, target=0, BranchCount=0, MissCount=0. Outputs therefore PredTakenF=0, PredTargetF=PCF+4, MispredictE=0.
- Reset mid-update: the update is discarded.

## Structure
- Package bpu_pkg holds:
  - index/tag width derivation functions;
  - WEAK_T and CTR_MAX constants;
  - the BTB entry struct.
- Sub-module sat_counter (WIDTH param, inc/dec/force-max/clear) is used for both direction counters and perf counters.
- Table stored as register arrays; no SRAM macro.

## Test plan
- Reset: rst=0, then release; PCF=0x40 → PredTakenF=0, PredTargetF=0x44, both counts 0.
- Allocate: UpdValidE, PCE=0x40, TakenE=1, PCTargetE=0x20, PredTakenE=0 → MispredictE=1, RedirectPCE=0x20. Next cycle PCF=0x40 → PredTakenF=1, PredTargetF=0x20; BranchCount=1, MissCount=1.
- Hysteresis: two not-taken updates on 0x40 with PredTakenE=1 → first gives MispredictE=1, RedirectPCE=0x44, ctr 2→1, PredTakenF=0; second ctr→0; MissCount=3.
- Aliasing (ENTRIES=16): 0x40 allocated, PCF=0x80 → PredTakenF=0. Taken update at 0x80 target 0x100 → PCF=0x80 predicts 0x100 and PCF=0x40 now misses.
- Jump and flush: UpdJumpE at 0x10 → ctr=3, predicted taken. FlushTbl asserted the same cycle as an update at 0x14 → both 0x10 and 0x14 miss afterwards.
- Saturation (CNT_W=4): 20 updates, all mispredicted → BranchCount=15, MissCount=15.
